// File: rtl/spi_pkg.sv
// Shared types for the SPI flash engine and the loader that feeds it.
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_ERASE = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_END   = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        LD_ERASE = 3'd0,
        LD_IDLE  = 3'd1,
        LD_WRITE = 3'd2,
        LD_END   = 3'd3,
        LD_DONE  = 3'd4
    } ld_state_t;

endpackage

// File: rtl/ram.sv
// Simple dual-port RAM: synchronous write, combinational read.
module ram #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem_q [2**ADDR_SIZE];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/flash_loader.sv
// Streams UART bytes into a ring of page buffers and drives the SPI engine
// through ERASE, one WRITE per sealed buffer, and a final END.
module flash_loader
    import spi_pkg::*;
#(
    parameter int          BLOCK_SIZE = 256,
    parameter int          NUM_BUFS   = 2,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    localparam int         BLOCK_BITS = $clog2(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  in_timeout,
    output cmd_t                  spi_cmd,
    input  logic                  spi_cmd_done,
    output logic [23:0]           spi_addr,
    output logic [BLOCK_BITS:0]   spi_len,
    input  logic [BLOCK_BITS-1:0] spi_rd_addr,
    output logic [7:0]            spi_rd_data,
    output logic                  done,
    output logic [15:0]           blocks_written
);

    localparam int PTR_W = $clog2(NUM_BUFS);
    localparam int FC_W  = $clog2(NUM_BUFS + 1);
    localparam int CNT_W = BLOCK_BITS + 1;

    ld_state_t        state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [23:0]      addr_q, addr_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] drain_ptr_q, drain_ptr_d;
    logic [FC_W-1:0]  full_cnt_q, full_cnt_d;
    logic             end_pending_q, end_pending_d;
    logic             done_q, done_d;
    logic [15:0]      blocks_q, blocks_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [CNT_W-1:0] buf_len_q [NUM_BUFS];
    logic [CNT_W-1:0] buf_len_d [NUM_BUFS];
    logic [7:0]       rd_bus [NUM_BUFS];

    logic             active, accept, timeout_hit, seal, wr_done;
    logic [CNT_W-1:0] fill_cnt_inc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BUFS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign active   = (state_q != LD_END) && (state_q != LD_DONE);
    assign in_ready = !rst && active && !end_pending_q && (full_cnt_q != FC_W'(NUM_BUFS));
    assign accept   = in_valid && in_ready;

    // A byte landing with the timeout is counted first; a block it completes
    // is sealed as full and the timeout then has nothing left to seal.
    assign fill_cnt_inc = fill_cnt_q + CNT_W'(accept);
    assign timeout_hit  = in_timeout && active && !end_pending_q;
    assign seal         = (fill_cnt_inc == CNT_W'(BLOCK_SIZE)) ||
                          (timeout_hit && (fill_cnt_inc != '0));
    assign wr_done      = (state_q == LD_WRITE) && spi_cmd_done;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        len_d         = len_q;
        drain_ptr_d   = drain_ptr_q;
        blocks_d      = blocks_q;
        done_d        = done_q;
        buf_len_d     = buf_len_q;
        fill_ptr_d    = fill_ptr_q;
        fill_cnt_d    = seal ? '0 : fill_cnt_inc;
        end_pending_d = end_pending_q || timeout_hit;
        full_cnt_d    = full_cnt_q + FC_W'(seal) - FC_W'(wr_done);
        rd_data_d     = rd_bus[drain_ptr_q];

        if (seal) begin
            buf_len_d[fill_ptr_q] = fill_cnt_inc;
            fill_ptr_d            = ptr_inc(fill_ptr_q);
        end

        case (state_q)
            LD_ERASE: if (spi_cmd_done) begin
                state_d = LD_IDLE;
                cmd_d   = CMD_NONE;
            end
            LD_IDLE: if (full_cnt_q != '0) begin
                state_d = LD_WRITE;
                cmd_d   = CMD_WRITE;
                len_d   = buf_len_q[drain_ptr_q];
            end else if (end_pending_q) begin
                state_d = LD_END;
                cmd_d   = CMD_END;
            end
            LD_WRITE: if (spi_cmd_done) begin
                state_d     = LD_IDLE;
                cmd_d       = CMD_NONE;
                drain_ptr_d = ptr_inc(drain_ptr_q);
                addr_d      = addr_q + 24'(BLOCK_SIZE);
                if (blocks_q != 16'hFFFF) blocks_d = blocks_q + 16'd1;
            end
            LD_END: if (spi_cmd_done) begin
                state_d = LD_DONE;
                cmd_d   = CMD_NONE;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LD_ERASE;
            cmd_q         <= CMD_ERASE;
            addr_q        <= BASE_ADDR;
            len_q         <= '0;
            fill_cnt_q    <= '0;
            fill_ptr_q    <= '0;
            drain_ptr_q   <= '0;
            full_cnt_q    <= '0;
            end_pending_q <= 1'b0;
            done_q        <= 1'b0;
            blocks_q      <= '0;
            rd_data_q     <= '0;
            for (int i = 0; i < NUM_BUFS; i++) buf_len_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            fill_cnt_q    <= fill_cnt_d;
            fill_ptr_q    <= fill_ptr_d;
            drain_ptr_q   <= drain_ptr_d;
            full_cnt_q    <= full_cnt_d;
            end_pending_q <= end_pending_d;
            done_q        <= done_d;
            blocks_q      <= blocks_d;
            rd_data_q     <= rd_data_d;
            buf_len_q     <= buf_len_d;
        end
    end

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
        ram #(
            .ADDR_SIZE(BLOCK_BITS),
            .DATA_SIZE(8)
        ) u_ram (
            .clk  (clk),
            .we   (accept && (fill_ptr_q == PTR_W'(g))),
            .waddr(fill_cnt_q[BLOCK_BITS-1:0]),
            .wdata(in_data),
            .raddr(spi_rd_addr),
            .rdata(rd_bus[g])
        );
    end

    assign spi_cmd        = cmd_q;
    assign spi_addr       = addr_q;
    assign spi_len        = len_q;
    assign spi_rd_data    = rd_data_q;
    assign done           = done_q;
    assign blocks_written = blocks_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader at default parameters (256-byte pages, 2 buffers).
module tb_flash_loader;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        in_timeout = 1'b0;
    cmd_t        spi_cmd;
    logic        spi_cmd_done = 1'b0;
    logic [23:0] spi_addr;
    logic [8:0]  spi_len;
    logic [7:0]  spi_rd_addr = '0;
    logic [7:0]  spi_rd_data;
    logic        done;
    logic [15:0] blocks_written;

    int checks = 0;
    int errors = 0;
    int acc;

    flash_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .in_timeout    (in_timeout),
        .spi_cmd       (spi_cmd),
        .spi_cmd_done  (spi_cmd_done),
        .spi_addr      (spi_addr),
        .spi_len       (spi_len),
        .spi_rd_addr   (spi_rd_addr),
        .spi_rd_data   (spi_rd_data),
        .done          (done),
        .blocks_written(blocks_written)
    );

    always #5 clk = ~clk;

    // Stream position k carries a byte that differs between the two buffers
    // at the same index, so reading the wrong buffer is visible.
    function automatic logic [7:0] pat(input int k);
        return 8'((k * 7) + (k >> 8) * 13);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_timeout = 1'b0;
        spi_cmd_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        spi_cmd_done = 1'b1;
        tick();
        spi_cmd_done = 1'b0;
    endtask

    task automatic pulse_timeout();
        in_timeout = 1'b1;
        tick();
        in_timeout = 1'b0;
    endtask

    task automatic erase_phase();
        repeat (10) tick();
        pulse_done();
    endtask

    // Offers n bytes from stream position start; stops if in_ready stays low.
    task automatic send_bytes(input int start, input int n, output int accepted);
        int guard;
        accepted = 0;
        for (int k = start; k < start + n; k++) begin
            in_valid = 1'b1;
            in_data  = pat(k);
            guard = 0;
            while (!in_ready && guard < 30) begin
                tick();
                guard++;
            end
            if (!in_ready) break;
            tick();
            accepted++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_cmd(input cmd_t exp, input string tag);
        int n = 0;
        while (spi_cmd !== exp && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(spi_cmd), 32'(exp));
    endtask

    task automatic rd_chk(input int idx, input int k, input string tag);
        spi_rd_addr = 8'(idx);
        tick();
        chk(tag, 32'(spi_rd_data), 32'(pat(k)));
    endtask

    initial begin
        // Reset values, sampled while rst is still high and after the edge.
        rst = 1'b1;
        tick();
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_cmd", 32'(spi_cmd), 32'(CMD_ERASE));
        chk("rst_addr", 32'(spi_addr), 0);
        chk("rst_len", 32'(spi_len), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_blocks", 32'(blocks_written), 0);
        chk("rst_rdata", 32'(spi_rd_data), 0);
        rst = 1'b0;
        #1;
        chk("ready_erase", 32'(in_ready), 1);

        // Two full pages, then a timeout with nothing partial to seal.
        erase_phase();
        chk("idle_cmd", 32'(spi_cmd), 32'(CMD_NONE));
        send_bytes(0, 512, acc);
        chk("t1_acc", 32'(acc), 512);
        pulse_timeout();
        chk("t1_ready_end", 32'(in_ready), 0);
        wait_cmd(CMD_WRITE, "t1_w0");
        chk("t1_w0_addr", 32'(spi_addr), 32'h000000);
        chk("t1_w0_len", 32'(spi_len), 256);
        rd_chk(5, 5, "t1_rd5");
        pulse_done();
        wait_cmd(CMD_WRITE, "t1_w1");
        chk("t1_w1_addr", 32'(spi_addr), 32'h000100);
        chk("t1_w1_len", 32'(spi_len), 256);
        rd_chk(255, 511, "t1_rd255");
        pulse_done();
        wait_cmd(CMD_END, "t1_end");
        chk("t1_blocks", 32'(blocks_written), 2);
        pulse_done();
        chk("t1_done", 32'(done), 1);
        chk("t1_cmd_none", 32'(spi_cmd), 32'(CMD_NONE));
        chk("t1_ready_done", 32'(in_ready), 0);

        // 300 bytes: full page then a 44-byte partial page.
        do_reset();
        erase_phase();
        send_bytes(0, 300, acc);
        chk("t2_acc", 32'(acc), 300);
        pulse_timeout();
        wait_cmd(CMD_WRITE, "t2_w0");
        chk("t2_w0_len", 32'(spi_len), 256);
        pulse_done();
        wait_cmd(CMD_WRITE, "t2_w1");
        chk("t2_w1_addr", 32'(spi_addr), 32'h000100);
        chk("t2_w1_len", 32'(spi_len), 44);
        rd_chk(0, 256, "t2_rd0");
        rd_chk(43, 299, "t2_rd43");
        pulse_done();
        wait_cmd(CMD_END, "t2_end");

        // Back-pressure with the engine stalled on the first WRITE.
        do_reset();
        erase_phase();
        send_bytes(0, 600, acc);
        chk("t3_acc_stall", 32'(acc), 512);
        chk("t3_ready_full", 32'(in_ready), 0);
        chk("t3_cmd", 32'(spi_cmd), 32'(CMD_WRITE));
        pulse_done();
        chk("t3_ready_resume", 32'(in_ready), 1);
        send_bytes(512, 88, acc);
        chk("t3_acc_rest", 32'(acc), 88);
        pulse_timeout();
        wait_cmd(CMD_WRITE, "t3_w1");
        chk("t3_w1_addr", 32'(spi_addr), 32'h000100);
        rd_chk(0, 256, "t3_rd_b1");
        pulse_done();
        wait_cmd(CMD_WRITE, "t3_w2");
        chk("t3_w2_addr", 32'(spi_addr), 32'h000200);
        chk("t3_w2_len", 32'(spi_len), 88);
        rd_chk(0, 512, "t3_rd_first");
        rd_chk(87, 599, "t3_rd_last");
        pulse_done();
        wait_cmd(CMD_END, "t3_end");
        pulse_done();
        chk("t3_blocks", 32'(blocks_written), 3);

        // 256th byte coincident with the timeout: one full page, no empty one.
        do_reset();
        erase_phase();
        send_bytes(0, 255, acc);
        in_valid = 1'b1;
        in_data = pat(255);
        in_timeout = 1'b1;
        tick();
        in_valid = 1'b0;
        in_timeout = 1'b0;
        wait_cmd(CMD_WRITE, "t4_w0");
        chk("t4_len", 32'(spi_len), 256);
        rd_chk(255, 255, "t4_rd255");
        pulse_done();
        tick();
        chk("t4_end", 32'(spi_cmd), 32'(CMD_END));
        pulse_done();
        chk("t4_blocks", 32'(blocks_written), 1);
        chk("t4_done", 32'(done), 1);

        // Timeout with no data, arriving during ERASE.
        do_reset();
        pulse_timeout();
        chk("t5_ready", 32'(in_ready), 0);
        chk("t5_still_erase", 32'(spi_cmd), 32'(CMD_ERASE));
        erase_phase();
        wait_cmd(CMD_END, "t5_end");
        pulse_done();
        chk("t5_done", 32'(done), 1);
        chk("t5_blocks", 32'(blocks_written), 0);

        // Reset in the middle of a WRITE.
        do_reset();
        erase_phase();
        send_bytes(0, 256, acc);
        pulse_done();
        wait_cmd(CMD_WRITE, "t6_w0");
        pulse_done();
        send_bytes(256, 256, acc);
        wait_cmd(CMD_WRITE, "t6_w1");
        chk("t6_w1_addr", 32'(spi_addr), 32'h000100);
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        chk("t6_cmd", 32'(spi_cmd), 32'(CMD_ERASE));
        chk("t6_addr", 32'(spi_addr), 32'h000000);
        chk("t6_len", 32'(spi_len), 0);
        chk("t6_blocks", 32'(blocks_written), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
